// File: rtl/outcome_classifier_if.sv
// outcome_classifier_if: feature-write, start and result signals of the classifier
interface outcome_classifier_if;
  logic wr;
  logic [2:0] idx;
  logic [13:0] value;
  logic start;
  logic busy;
  logic done;
  logic outcome;
  logic [3:0] resultado;
  logic [35:0] score;
  modport master(output wr, idx, value, start, input busy, done, outcome, resultado, score);
  modport slave(input wr, idx, value, start, output busy, done, outcome, resultado, score);
endinterface

// File: rtl/outcome_classifier.sv
// outcome_classifier: one-term-per-cycle weighted sum of seven stored features, sign gives the outcome
module outcome_classifier #(
  parameter logic signed [15:0] W_PREG = 16'sd12,
  parameter logic signed [15:0] W_GLU = 16'sd4,
  parameter logic signed [15:0] W_BP = -16'sd1,
  parameter logic signed [15:0] W_SKIN = 16'sd0,
  parameter logic signed [15:0] W_INS = 16'sd0,
  parameter logic signed [15:0] W_BMI = 16'sd9,
  parameter logic signed [15:0] W_AGE = 16'sd2,
  parameter logic signed [31:0] BIAS = -32'sd900
) (
  input logic clk,
  input logic clear,
  outcome_classifier_if.slave bus
);
  localparam logic IDLE = 1'b0;
  localparam logic CALC = 1'b1;
  localparam logic [127:0] wts = {16'd0, W_AGE, W_BMI, W_INS, W_SKIN, W_BP, W_GLU, W_PREG};
  logic state;
  logic [2:0] cnt;
  logic [35:0] acc;
  logic [35:0] term;
  logic [35:0] sum;
  logic [35:0] score;
  logic [7:0][13:0] feat;
  logic [7:0][13:0] snap;
  logic [15:0] wsel;
  logic [13:0] fsel;
  logic [13:0] sat;
  logic done;
  logic outcome;
  always_comb begin
    wsel = wts[{cnt, 4'b0} +: 16];
    fsel = snap[cnt];
    term = {{20{wsel[15]}}, wsel} * {22'd0, fsel};
    sum = acc + term;
    sat = bus.value > 14'd9999 ? 14'd9999 : bus.value;
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      score <= '0;
      done <= 1'b0;
      outcome <= 1'b0;
      feat <= '0;
      snap <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (bus.wr && bus.idx != 3'd7) feat[bus.idx] <= sat;
        if (bus.start) begin
          state <= CALC;
          cnt <= '0;
          acc <= {{4{BIAS[31]}}, BIAS};
          snap <= feat;
        end
      end else begin
        acc <= sum;
        cnt <= cnt + 3'd1;
        if (cnt == 3'd6) begin
          score <= sum;
          outcome <= ~sum[35];
          done <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end
  assign bus.busy = state;
  assign bus.done = done;
  assign bus.outcome = outcome;
  assign bus.resultado = {3'b000, outcome};
  assign bus.score = score;
endmodule

// File: tb/tb_outcome_classifier.sv
// tb_outcome_classifier: vector table plus corner sequences, scoreboard checked on each done pulse
module tb_outcome_classifier;
  logic clk = 1'b0;
  logic clear = 1'b0;
  outcome_classifier_if bus();
  outcome_classifier dut(.clk(clk), .clear(clear), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [6:0][13:0] f;
    longint s;
    bit o;
  } vec_t;
  typedef struct {
    longint s;
    bit o;
  } exp_t;
  vec_t vecs[6];
  exp_t q[$];
  int n_cmp = 0;
  int n_fail = 0;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic write(input logic [2:0] i, input logic [13:0] v);
    bus.wr = 1'b1;
    bus.idx = i;
    bus.value = v;
    tick();
    bus.wr = 1'b0;
  endtask
  task automatic push(input longint s, input bit o);
    exp_t e;
    e.s = s;
    e.o = o;
    q.push_back(e);
  endtask
  task automatic run_eval(input string name, input bit inject);
    int lat;
    int nbusy;
    bit seen;
    exp_t e;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.wr = 1'b0;
    lat = 0;
    nbusy = bus.busy ? 1 : 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      if (inject && lat == 2) begin
        bus.wr = 1'b1;
        bus.idx = 3'd1;
        bus.value = 14'd200;
        bus.start = 1'b1;
      end
      tick();
      bus.wr = 1'b0;
      bus.start = 1'b0;
      lat++;
      if (bus.done) seen = 1'b1;
      else if (bus.busy) nbusy++;
    end
    check({name, " done_seen"}, seen, 1);
    check({name, " latency"}, lat, 7);
    check({name, " busy_cycles"}, nbusy, 7);
    check({name, " busy_at_done"}, bus.busy, 0);
    if (q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s scoreboard: got done with empty queue expected none", name);
    end else begin
      e = q.pop_front();
      check({name, " score"}, $signed(bus.score), e.s);
      check({name, " outcome"}, bus.outcome, e.o);
      check({name, " resultado"}, bus.resultado, e.o ? 1 : 0);
    end
    tick();
    check({name, " done_width"}, bus.done, 0);
    check({name, " hold_score"}, $signed(bus.score), e.s);
  endtask
  initial begin
    int extra;
    bus.wr = 1'b0;
    bus.idx = '0;
    bus.value = '0;
    bus.start = 1'b0;
    vecs[0].f = {14'd50, 14'd33, 14'd0, 14'd35, 14'd72, 14'd150, 14'd6};
    vecs[0].s = 97;
    vecs[0].o = 1;
    vecs[1].f = {14'd31, 14'd26, 14'd0, 14'd29, 14'd66, 14'd85, 14'd1};
    vecs[1].s = -318;
    vecs[1].o = 0;
    vecs[2].f = '0;
    vecs[2].s = -900;
    vecs[2].o = 0;
    vecs[3].f = {14'd0, 14'd100, 14'd0, 14'd0, 14'd0, 14'd0, 14'd0};
    vecs[3].s = 0;
    vecs[3].o = 1;
    vecs[4].f = {14'd0, 14'd0, 14'd0, 14'd0, 14'd9999, 14'd0, 14'd0};
    vecs[4].s = -10899;
    vecs[4].o = 0;
    vecs[5].f = {7{14'd9999}};
    vecs[5].s = 259074;
    vecs[5].o = 1;
    clear = 1'b1;
    bus.start = 1'b1;
    bus.wr = 1'b1;
    bus.idx = 3'd0;
    bus.value = 14'd5;
    tick();
    clear = 1'b0;
    bus.start = 1'b0;
    bus.wr = 1'b0;
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset outcome", bus.outcome, 0);
    check("reset resultado", bus.resultado, 0);
    check("reset score", $signed(bus.score), 0);
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 7; i++) write(3'(i), vecs[v].f[i]);
      push(vecs[v].s, vecs[v].o);
      run_eval($sformatf("vec%0d", v), 1'b0);
    end
    for (int i = 0; i < 7; i++) write(3'(i), vecs[0].f[i]);
    push(97, 1);
    run_eval("busy_ignore", 1'b1);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done) extra++;
    end
    check("busy_ignore second_done", extra, 0);
    push(97, 1);
    run_eval("busy_ignore rerun", 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort busy", bus.busy, 0);
    check("abort score", $signed(bus.score), 0);
    check("abort outcome", bus.outcome, 0);
    check("abort resultado", bus.resultado, 0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done) extra++;
    end
    check("abort no_done", extra, 0);
    push(-900, 0);
    run_eval("after_clear", 1'b0);
    write(3'd5, 14'd12000);
    write(3'd7, 14'd5000);
    push(89091, 1);
    run_eval("saturate", 1'b0);
    bus.wr = 1'b1;
    bus.idx = 3'd1;
    bus.value = 14'd100;
    push(89091, 1);
    run_eval("start_with_wr", 1'b0);
    push(89491, 1);
    run_eval("wr_took_effect", 1'b0);
    check("scoreboard empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
